// File: rtl/alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_pkg: shared op encoding, width default and requester IDs for the ALU arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_op_e;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  localparam int   WIDTH_DEFAULT = 16;
  localparam logic REQ_EXEC      = 1'b0;
  localparam logic REQ_PC        = 1'b1;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_arbiter_if: two request ports, response channel and condition flags
// Rev 1.0
// ---------------------------------------------------------------------------
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) ();

  logic             i_req0_valid;
  logic             o_req0_ready;
  logic             i_req0_op;
  logic [WIDTH-1:0] i_req0_a;
  logic [WIDTH-1:0] i_req0_b;

  logic             i_req1_valid;
  logic             o_req1_ready;
  logic             i_req1_op;
  logic [WIDTH-1:0] i_req1_a;
  logic [WIDTH-1:0] i_req1_b;

  logic             o_rsp_valid;
  logic             i_rsp_ready;
  logic             o_rsp_id;
  logic [WIDTH-1:0] o_rsp_data;
  logic             o_rsp_n;
  logic             o_rsp_z;

  logic             o_flag_n;
  logic             o_flag_z;

  // Arbiter side
  modport slave (
    input  i_req0_valid, i_req0_op, i_req0_a, i_req0_b,
    input  i_req1_valid, i_req1_op, i_req1_a, i_req1_b,
    input  i_rsp_ready,
    output o_req0_ready, o_req1_ready,
    output o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_n, o_rsp_z,
    output o_flag_n, o_flag_z
  );

  // Requester / consumer side
  modport master (
    output i_req0_valid, i_req0_op, i_req0_a, i_req0_b,
    output i_req1_valid, i_req1_op, i_req1_a, i_req1_b,
    output i_rsp_ready,
    input  o_req0_ready, o_req1_ready,
    input  o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_n, o_rsp_z,
    input  o_flag_n, o_flag_z
  );

endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu: combinational WIDTH-bit add/subtract with N/Z flags, wrapping arithmetic
// Rev 1.0
// ---------------------------------------------------------------------------
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  alu_op_e          i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_n,
  output logic             o_z
);

  always_comb begin
    o_result = (i_op == ALU_SUB) ? (i_a - i_b) : (i_a + i_b);
  end

  assign o_n = o_result[WIDTH-1];
  assign o_z = (o_result == '0);

endmodule
`default_nettype wire

// File: rtl/alu_rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_rr_pick: two-input round-robin picker; a tie goes to the port not granted last
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_rr_pick
  import alu_pkg::*;
(
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last_grant,
  output logic o_grant_id,
  output logic o_any_valid
);

  always_comb begin
    o_any_valid = i_valid0 | i_valid1;
    if (i_valid0 && i_valid1) begin
      o_grant_id = ~i_last_grant;
    end else if (i_valid1) begin
      o_grant_id = REQ_PC;
    end else begin
      o_grant_id = REQ_EXEC;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_arbiter: round-robin share of one ALU between execute and PC ports,
// with a one-deep response register and port-0-only condition flags. Rev 1.0
// ---------------------------------------------------------------------------
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  alu_arbiter_if.slave  bus
);

  rsp_state_e       rsp_state_q;
  logic             last_grant_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_n_q;
  logic             rsp_z_q;
  logic             flag_n_q;
  logic             flag_z_q;

  logic             accept_ok;
  logic             grant_id;
  logic             any_valid;
  logic             transfer;
  alu_op_e          alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_n;
  logic             alu_z;

  alu_rr_pick u_pick (
    .i_valid0     (bus.i_req0_valid),
    .i_valid1     (bus.i_req1_valid),
    .i_last_grant (last_grant_q),
    .o_grant_id   (grant_id),
    .o_any_valid  (any_valid)
  );

  assign accept_ok = (rsp_state_q == RSP_EMPTY) || bus.i_rsp_ready;
  // Gating with the reset keeps both readies low while reset is held.
  assign transfer  = i_reset_n && accept_ok && any_valid;

  assign bus.o_req0_ready = transfer && (grant_id == REQ_EXEC);
  assign bus.o_req1_ready = transfer && (grant_id == REQ_PC);

  always_comb begin
    if (grant_id == REQ_PC) begin
      alu_op = alu_op_e'(bus.i_req1_op);
      alu_a  = bus.i_req1_a;
      alu_b  = bus.i_req1_b;
    end else begin
      alu_op = alu_op_e'(bus.i_req0_op);
      alu_a  = bus.i_req0_a;
      alu_b  = bus.i_req0_b;
    end
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .i_op     (alu_op),
    .i_a      (alu_a),
    .i_b      (alu_b),
    .o_result (alu_res),
    .o_n      (alu_n),
    .o_z      (alu_z)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rsp_state_q  <= RSP_EMPTY;
      last_grant_q <= REQ_PC;
      rsp_id_q     <= REQ_EXEC;
      rsp_data_q   <= '0;
      rsp_n_q      <= 1'b0;
      rsp_z_q      <= 1'b1;
      flag_n_q     <= 1'b0;
      flag_z_q     <= 1'b1;
    end else begin
      case (rsp_state_q)
        RSP_EMPTY: if (transfer) rsp_state_q <= RSP_FULL;
        RSP_FULL:  if (bus.i_rsp_ready && !transfer) rsp_state_q <= RSP_EMPTY;
        default:   rsp_state_q <= RSP_EMPTY;
      endcase
      if (transfer) begin
        last_grant_q <= grant_id;
        rsp_id_q     <= grant_id;
        rsp_data_q   <= alu_res;
        rsp_n_q      <= alu_n;
        rsp_z_q      <= alu_z;
        if (grant_id == REQ_EXEC) begin
          flag_n_q <= alu_n;
          flag_z_q <= alu_z;
        end
      end
    end
  end

  assign bus.o_rsp_valid = (rsp_state_q == RSP_FULL);
  assign bus.o_rsp_id    = rsp_id_q;
  assign bus.o_rsp_data  = rsp_data_q;
  assign bus.o_rsp_n     = rsp_n_q;
  assign bus.o_rsp_z     = rsp_z_q;
  assign bus.o_flag_n    = flag_n_q;
  assign bus.o_flag_z    = flag_z_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_arbiter: directed and random stimulus against a behavioural model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(16)) bus ();

  alu_arbiter #(.WIDTH(16)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model of the observable state
  logic        m_valid, m_id, m_n, m_z, m_fn, m_fz, m_last;
  logic [15:0] m_data;
  logic        took0, took1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_id = 1'b0; m_data = 16'h0000; m_n = 1'b0; m_z = 1'b1;
    m_fn = 1'b0; m_fz = 1'b1; m_last = 1'b1;
    took0 = 1'b0; took1 = 1'b0;
  endtask

  task automatic drive(input logic v0, input logic op0, input logic [15:0] a0, input logic [15:0] b0,
                       input logic v1, input logic op1, input logic [15:0] a1, input logic [15:0] b1,
                       input logic rr);
    bus.i_req0_valid = v0; bus.i_req0_op = op0; bus.i_req0_a = a0; bus.i_req0_b = b0;
    bus.i_req1_valid = v1; bus.i_req1_op = op1; bus.i_req1_a = a1; bus.i_req1_b = b1;
    bus.i_rsp_ready  = rr;
  endtask

  // One clock: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic tick();
    logic        room, winner, e_r0, e_r1, op;
    logic [15:0] a, b, res;
    room   = !m_valid || bus.i_rsp_ready;
    winner = (bus.i_req0_valid && bus.i_req1_valid) ? !m_last : bus.i_req1_valid;
    e_r0   = room && bus.i_req0_valid && !winner;
    e_r1   = room && bus.i_req1_valid && winner;
    @(negedge clk);
    chk("req0_ready", bus.o_req0_ready, e_r0);
    chk("req1_ready", bus.o_req1_ready, e_r1);
    chk("rsp_valid",  bus.o_rsp_valid,  m_valid);
    chk("rsp_id",     bus.o_rsp_id,     m_id);
    chk("rsp_data",   bus.o_rsp_data,   m_data);
    chk("rsp_n",      bus.o_rsp_n,      m_n);
    chk("rsp_z",      bus.o_rsp_z,      m_z);
    chk("flag_n",     bus.o_flag_n,     m_fn);
    chk("flag_z",     bus.o_flag_z,     m_fz);
    @(posedge clk);
    took0 = e_r0;
    took1 = e_r1;
    if (e_r0 || e_r1) begin
      op  = e_r1 ? bus.i_req1_op : bus.i_req0_op;
      a   = e_r1 ? bus.i_req1_a  : bus.i_req0_a;
      b   = e_r1 ? bus.i_req1_b  : bus.i_req0_b;
      res = op ? 16'(a - b) : 16'(a + b);
      m_valid = 1'b1;
      m_id    = e_r1;
      m_data  = res;
      m_n     = res[15];
      m_z     = (res == 16'h0000);
      m_last  = e_r1;
      if (e_r0) begin
        m_fn = m_n;
        m_fz = m_z;
      end
    end else if (m_valid && bus.i_rsp_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  initial begin
    model_reset();
    drive(1'b1, 1'b0, 16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0002, 16'h0002, 1'b1);
    #12;
    chk("reset_ready0", bus.o_req0_ready, 1'b0);
    chk("reset_ready1", bus.o_req1_ready, 1'b0);
    chk("reset_valid",  bus.o_rsp_valid,  1'b0);
    chk("reset_id",     bus.o_rsp_id,     1'b0);
    chk("reset_data",   bus.o_rsp_data,   16'h0000);
    chk("reset_rsp_z",  bus.o_rsp_z,      1'b1);
    chk("reset_flag_n", bus.o_flag_n,     1'b0);
    chk("reset_flag_z", bus.o_flag_z,     1'b1);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Port 0 add
    drive(1'b1, 1'b0, 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    #1;
    chk("add_valid", bus.o_rsp_valid, 1'b1);
    chk("add_id",    bus.o_rsp_id,    1'b0);
    chk("add_data",  bus.o_rsp_data,  16'h0007);
    chk("add_nz",    {bus.o_rsp_n, bus.o_rsp_z}, 2'b00);
    chk("add_flags", {bus.o_flag_n, bus.o_flag_z}, 2'b00);

    // Port 1 subtract to zero: flags untouched
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0005, 16'h0005, 1'b1);
    tick();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    #1;
    chk("p1_data",   bus.o_rsp_data, 16'h0000);
    chk("p1_id",     bus.o_rsp_id,   1'b1);
    chk("p1_z",      bus.o_rsp_z,    1'b1);
    chk("p1_flag_z", bus.o_flag_z,   1'b0);

    // Continuous tie: alternating grants starting with port 0
    drive(1'b1, 1'b0, 16'h0010, 16'h0001, 1'b1, 1'b0, 16'h0020, 16'h0002, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("tie_id", bus.o_rsp_id, (i % 2 == 0) ? 1'b0 : 1'b1);
    end

    // Port 0 underflow, then wrap-to-zero add
    drive(1'b1, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    tick();
    chk("under_data",   bus.o_rsp_data, 16'hFFFF);
    chk("under_n",      bus.o_rsp_n,    1'b1);
    chk("under_flag_n", bus.o_flag_n,   1'b1);
    drive(1'b1, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    tick();
    chk("wrap_data",   bus.o_rsp_data, 16'h0000);
    chk("wrap_z",      bus.o_rsp_z,    1'b1);
    chk("wrap_flag_z", bus.o_flag_z,   1'b1);

    // Backpressure with the response full
    drive(1'b1, 1'b0, 16'h1111, 16'h2222, 1'b1, 1'b0, 16'h3333, 16'h4444, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_data", bus.o_rsp_data, 16'h0000);
    end
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h3333, 16'h4444, 1'b1);
    tick();
    chk("reload_valid", bus.o_rsp_valid, 1'b1);
    chk("reload_id",    bus.o_rsp_id,    1'b1);
    chk("reload_data",  bus.o_rsp_data,  16'h7777);

    // Asynchronous reset while full
    drive(1'b1, 1'b0, 16'h0001, 16'h0002, 1'b1, 1'b0, 16'h0003, 16'h0004, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid",  bus.o_rsp_valid,  1'b0);
    chk("arst_flag_z", bus.o_flag_z,     1'b1);
    chk("arst_ready0", bus.o_req0_ready, 1'b0);
    chk("arst_ready1", bus.o_req1_ready, 1'b0);
    model_reset();
    @(posedge clk); #3;
    rst_n = 1'b1;
    bus.i_rsp_ready = 1'b1;
    tick();
    chk("post_rst_tie", bus.o_rsp_id, 1'b0);

    // Random traffic; a pending request is held until accepted
    took0 = 1'b1; took1 = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!bus.i_req0_valid || took0) begin
        bus.i_req0_valid = 1'($urandom_range(0, 1));
        bus.i_req0_op    = 1'($urandom_range(0, 1));
        bus.i_req0_a     = 16'($urandom());
        bus.i_req0_b     = ($urandom_range(0, 7) == 0) ? bus.i_req0_a : 16'($urandom());
      end
      if (!bus.i_req1_valid || took1) begin
        bus.i_req1_valid = 1'($urandom_range(0, 1));
        bus.i_req1_op    = 1'($urandom_range(0, 1));
        bus.i_req1_a     = 16'($urandom());
        bus.i_req1_b     = 16'($urandom());
      end
      bus.i_rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 16-bit `alu` between two requesters: port 0 (execute stage) and port 1 (PC/address incrementer). Each port uses a valid/ready handshake. Requests are granted round-robin. The ALU result and its N/Z flags are captured in a one-deep registered response stage that carries the requester ID. The block sits between the control unit and the `alu` instance; a persistent N/Z condition-flag register for branch logic is updated only by port-0 results.

## Interface
- `WIDTH`, 16, operand/result width; must match `alu`.
- `i_clk`  in  1  rising-edge clock.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_req0_valid`  in  1  port-0 request valid.
- `o_req0_ready`  out  1  port-0 request accepted this cycle.
- `i_req0_op`  in  1  port-0 op select: 0 = add, 1 = subtract (a−b).
- `i_req0_a`, `i_req0_b`  in  WIDTH  port-0 operands.
- `i_req1_valid`, `o_req1_ready`, `i_req1_op`, `i_req1_a`, `i_req1_b`: port-1 equivalents.
- `o_rsp_valid`  out  1  response register holds a result.
- `i_rsp_ready`  in  1  consumer takes the response.
- `o_rsp_id`  out  1  requester of the held result.
- `o_rsp_data`  out  WIDTH  ALU result.
- `o_rsp_n`, `o_rsp_z`  out  1  N/Z flags of `o_rsp_data`.
- `o_flag_n`, `o_flag_z`  out  1  condition flags; updated on port-0 results only.

## Operation
- A request transfers when valid && ready on the same edge. At most one port is accepted per cycle.
- `accept_ok = !o_rsp_valid || i_rsp_ready`: the response register is empty, or is being drained this cycle.
- Grant selection when `accept_ok`:
  - Only one port valid: that port wins.
  - Both ports valid: the port not granted last wins.
  - `last_grant` updates only on an actual transfer.
- `o_reqN_ready = accept_ok && (granted == N)`.
  - Ready is asserted only to the winning port.
  - Ready is combinational from the valids and `i_rsp_ready`. There is no ready→valid dependency the other way.
- The operand mux feeds the `alu` combinationally from the granted port.
- On transfer, the response register captures `{id, result, n, z}` and `o_rsp_valid` goes to 1.
  - Port 0: `o_flag_n`/`o_flag_z` also load the n/z of this result on the same edge.
- Response drain: `o_rsp_valid && i_rsp_ready` with no new transfer clears `o_rsp_valid`. With a new transfer in the same cycle, the register reloads and `o_rsp_valid` stays 1.
- Response register state:
  - EMPTY → FULL on transfer.
  - FULL → EMPTY on drain without transfer.
  - FULL → FULL on drain with transfer, or on stall.
- While FULL and `!i_rsp_ready`, the response outputs are held stable and both ready outputs are 0.
- Arithmetic: results wrap modulo 2^WIDTH. There is no carry/overflow output.
  - `o_rsp_n` = result[WIDTH−1].
  - `o_rsp_z` = result == 0.
- Requesters must hold valid and operands stable until their ready is seen; the arbiter does not check this.

## Timing
- Latency: request accepted at edge T → `o_rsp_valid` = 1 after edge T; data is visible in the cycle T..T+1.
- Throughput: 1 result per cycle when `i_rsp_ready` is held high.
- Reset (async assert, sync-safe deassert) sets:
  - `o_rsp_valid` = 0, `o_rsp_id` = 0, `o_rsp_data` = 0, `o_rsp_n` = 0, `o_rsp_z` = 1.
  - `o_flag_n` = 0, `o_flag_z` = 1.
  - `last_grant` = 1, so port 0 wins the first tie.
- Both ready outputs are 0 while `i_reset_n` = 0.
- Reset mid-operation discards the held response and any in-flight handshake. No partial state survives.
- Port-1 results never alter `o_flag_*`, even when back-to-back with port 0.

## Structure
- Package `alu_pkg`:
  - `alu_op_e` (`ALU_ADD` = 0, `ALU_SUB` = 1).
  - `WIDTH_DEFAULT` = 16.
  - Requester ID constants `REQ_EXEC` = 0, `REQ_PC` = 1.
- Sub-module `alu_rr_pick`: 2-input round-robin picker.
  - Inputs: the two valids, `last_grant`.
  - Outputs: `grant_id`, `any_valid`.
  - Purely combinational.
- Instantiates the existing `alu` once. The arbiter holds all sequential state: response register, `last_grant`, flag register.

## Test plan
- Port 0 only, op = 0, a = 0x0003, b = 0x0004, `i_rsp_ready` = 1 → next cycle: `o_rsp_valid` = 1, `id` = 0, `data` = 0x0007, n = 0, z = 0; `o_flag_*` = 0/0.
- Port 1 only, op = 1, a = 0x0005, b = 0x0005 → `data` = 0x0000, z = 1; `o_flag_z` keeps its prior value (no update from port 1).
- Both ports valid continuously for 4 cycles, `i_rsp_ready` = 1 → grant ids 0, 1, 0, 1, starting with 0 after reset.
- Port 0, op = 1, a = 0x0000, b = 0x0001 → `data` = 0xFFFF, n = 1, z = 0; `o_flag_n` = 1. Also: a = 0xFFFF + b = 0x0001 → 0x0000, z = 1.
- Backpressure: hold `i_rsp_ready` = 0 with the response FULL → both ready outputs = 0 and the response stays stable for 3 cycles. Raise `i_rsp_ready` with port 1 valid → drain and reload in the same cycle; `o_rsp_valid` stays 1 and `id` = 1.
- Assert `i_reset_n` = 0 mid-stream with the response FULL → `o_rsp_valid` = 0 immediately (async), `o_flag_z` = 1. After release, a tie grants port 0.
